sd_init_sequencer: RTL
======================

Name: sd_init_sequencer

Overview:
Hardware SD-card SPI-mode initialisation sequencer. It sits above the SD command engine (cmd/arg/crc/nresponse/start/done) and the SPI idle-clock generator. It runs the power-up flow: 80 dummy clocks with CS high, CMD0, CMD8, a CMD55/ACMD41 poll loop and CMD58. It then reports card ready, card type and capacity class, or an error code, to the system.

Parameters:
DUMMY_BYTES, 10, number of 0xFF bytes sent with cs_n high before CMD0 (10 bytes = 80 clocks)
ACMD41_RETRIES, 1000, maximum number of ACMD41 attempts before a timeout error
CMD_TIMEOUT, 65535, maximum clk cycles to wait for sd_done or dummy_done in any single step

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
init_start  in  1  single-cycle request to run initialisation
init_busy  out  1  sequence in progress
init_done  out  1  card initialised; held until the next accepted init_start
init_error  out  1  sequence failed; held until the next accepted init_start
err_code  out  3  1=CMD0, 2=CMD8, 3=CMD55/ACMD41 R1, 4=ACMD41 retries, 5=step timeout, 6=CMD58
card_v2  out  1  card answered CMD8 with a valid echo
card_hc  out  1  CCS bit from CMD58 (SDHC/SDXC)
cs_n  out  1  card chip select to the SPI pins
dummy_start  out  1  single-cycle pulse; send dummy_count bytes of 0xFF
dummy_count  out  8  equals DUMMY_BYTES
dummy_done  in  1  single-cycle pulse; dummy bytes complete
sd_start  out  1  single-cycle pulse to the command engine
sd_cmd  out  6  command index
sd_arg  out  32  command argument
sd_crc  out  7  CRC7, without the stop bit
sd_nresponse  out  3  response bytes expected after R1 (0 or 4)
sd_done  in  1  single-cycle pulse; command and response complete
sd_r1  in  8  R1 byte; valid in the sd_done cycle
sd_resp  in  32  trailing response bytes, big-endian; valid in the sd_done cycle

Behaviour:
- Reset values: all outputs 0 except cs_n=1 and dummy_count=DUMMY_BYTES. FSM returns to IDLE. Retry and timeout counters are cleared.
- Reset mid-operation aborts immediately with no further strobes.
- States: IDLE, DUMMY_ISSUE, DUMMY_WAIT, then an ISSUE/WAIT pair for each of CMD0, CMD8, CMD55, ACMD41, CMD58, then DONE, ERROR.
- init_start is accepted only in IDLE, DONE or ERROR; it is ignored while busy. On acceptance, init_done, init_error, err_code, card_v2 and card_hc are cleared, init_busy is set, and the FSM goes to DUMMY_ISSUE.
- Latency: dummy_start pulses in the cycle after init_start is sampled.
- cs_n:
  - High in IDLE, DUMMY_*, DONE and ERROR.
  - Driven low on entry to CMD0_ISSUE; stays low through CMD58.
- ISSUE states:
  - Drive sd_cmd, sd_arg, sd_crc and sd_nresponse; pulse sd_start for exactly 1 cycle; go to WAIT.
  - These outputs stay stable from ISSUE until sd_done.
  - The timeout counter clears in ISSUE.
- WAIT states:
  - Count cycles. When the count reaches CMD_TIMEOUT without a done pulse, go to ERROR with err_code=5.
  - sd_done and the timeout limit in the same cycle: sd_done wins.
- Command table (cmd, arg, crc, nresp):
  - CMD0: 0x00000000, 7'h4A, 0
  - CMD8: 0x000001AA, 7'h43, 4
  - CMD55: 0, 7'h32, 0
  - ACMD41: 0x40000000 if card_v2, else 0; crc 7'h3B; 0
  - CMD58: 0, 7'h7E, 4
- Response evaluation (in the sd_done cycle):
  - CMD0: R1==0x01 goes to CMD8; otherwise err 1.
  - CMD8:
    - R1==0x01 and sd_resp[11:0]==0x1AA: card_v2=1, go to CMD55.
    - R1==0x05 (illegal command): card_v2=0, go to CMD55.
    - Otherwise: err 2.
  - CMD55: R1 in {0x00, 0x01} goes to ACMD41; otherwise err 3.
  - ACMD41:
    - R1==0x00: go to CMD58 if card_v2, else DONE with card_hc=0.
    - R1==0x01: retry counter +1. If the count equals ACMD41_RETRIES, err 4; else go to CMD55.
    - Other values: err 3.
  - CMD58: R1==0x00 sets card_hc=sd_resp[30] and goes to DONE; otherwise err 6.
- Retry counter: width clog2(ACMD41_RETRIES+1). It is cleared on init_start and never wraps.
- DONE: init_done=1, init_busy=0, cs_n=1.
- ERROR: init_error=1, init_busy=0, cs_n=1, err_code held.
- Stray sd_done or dummy_done pulses outside the matching WAIT state are ignored.

Test Plan:
1. v2 SDHC card. init_start; model returns R1 0x01 to CMD0; 0x01 with resp 0x000001AA to CMD8; 0x01 to ACMD41 twice, then 0x00; CMD58 resp 0x40FF8000. Required: init_done=1, card_v2=1, card_hc=1, exactly 3 ACMD41 issues, one dummy_start with count 10.
2. v1 card. CMD8 R1=0x05. Required: ACMD41 arg 0, no CMD58 issued, init_done=1, card_v2=0, card_hc=0.
3. CMD0 returns 0xFF. Required: init_error=1, err_code=1, cs_n=1, no CMD8 issued.
4. ACMD41 always returns 0x01, with ACMD41_RETRIES=4. Required: 4 ACMD41 issues, then err_code=4.
5. sd_done never asserted after CMD8, with CMD_TIMEOUT=100. Required: err_code=5 after 100 WAIT cycles.
6. rst_n low during CMD55_WAIT, then released, then init_start. Required: outputs at reset values, and a clean full sequence beginning with dummy_start.

Source files
------------

// File: rtl/sd_init_sequencer_if.sv
// Link between the SD init sequencer and the SPI side: command engine,
// dummy-clock generator and the card chip select.
interface sd_init_sequencer_if;
  logic        cs_n;
  logic        dummy_start;
  logic [7:0]  dummy_count;
  logic        dummy_done;
  logic        sd_start;
  logic [5:0]  sd_cmd;
  logic [31:0] sd_arg;
  logic [6:0]  sd_crc;
  logic [2:0]  sd_nresponse;
  logic        sd_done;
  logic [7:0]  sd_r1;
  logic [31:0] sd_resp;

  modport master (
    output cs_n, dummy_start, dummy_count, sd_start, sd_cmd, sd_arg, sd_crc, sd_nresponse,
    input  dummy_done, sd_done, sd_r1, sd_resp
  );

  modport slave (
    input  cs_n, dummy_start, dummy_count, sd_start, sd_cmd, sd_arg, sd_crc, sd_nresponse,
    output dummy_done, sd_done, sd_r1, sd_resp
  );
endinterface

// File: rtl/sd_init_sequencer.sv
// SD-card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41 poll,
// CMD58, then reports ready, card type and capacity class or an error code.
module sd_init_sequencer #(
  parameter int DUMMY_BYTES    = 10,
  parameter int ACMD41_RETRIES = 1000,
  parameter int CMD_TIMEOUT    = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_start,
  output logic                       init_busy,
  output logic                       init_done,
  output logic                       init_error,
  output logic [2:0]                 err_code,
  output logic                       card_v2,
  output logic                       card_hc,
  sd_init_sequencer_if.master        sd_if
);

  localparam int RW = $clog2(ACMD41_RETRIES + 1);
  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(ACMD41_RETRIES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CMD_TIMEOUT - 1);

  localparam logic [2:0] ERR_CMD0    = 3'd1;
  localparam logic [2:0] ERR_CMD8    = 3'd2;
  localparam logic [2:0] ERR_R1      = 3'd3;
  localparam logic [2:0] ERR_RETRIES = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_CMD58   = 3'd6;

  typedef enum logic [3:0] {
    IDLE, DUMMY_ISSUE, DUMMY_WAIT,
    CMD0_ISSUE, CMD0_WAIT, CMD8_ISSUE, CMD8_WAIT,
    CMD55_ISSUE, CMD55_WAIT, ACMD41_ISSUE, ACMD41_WAIT,
    CMD58_ISSUE, CMD58_WAIT, DONE, ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          init_busy_q, init_busy_d;
  logic          init_done_q, init_done_d;
  logic          init_error_q, init_error_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          card_v2_q, card_v2_d;
  logic          card_hc_q, card_hc_d;
  logic          cs_n_q, cs_n_d;
  logic          dummy_start_q, dummy_start_d;
  logic          sd_start_q, sd_start_d;
  logic [5:0]    sd_cmd_q, sd_cmd_d;
  logic [31:0]   sd_arg_q, sd_arg_d;
  logic [6:0]    sd_crc_q, sd_crc_d;
  logic [2:0]    sd_nresp_q, sd_nresp_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          go_done;
  logic          go_error;
  logic [2:0]    fail_code;

  always_comb begin
    state_d       = state_q;
    init_busy_d   = init_busy_q;
    init_done_d   = init_done_q;
    init_error_d  = init_error_q;
    err_code_d    = err_code_q;
    card_v2_d     = card_v2_q;
    card_hc_d     = card_hc_q;
    cs_n_d        = cs_n_q;
    dummy_start_d = 1'b0;
    sd_start_d    = 1'b0;
    sd_cmd_d      = sd_cmd_q;
    sd_arg_d      = sd_arg_q;
    sd_crc_d      = sd_crc_q;
    sd_nresp_d    = sd_nresp_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    go_done       = 1'b0;
    go_error      = 1'b0;
    fail_code     = 3'd0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (init_start) begin
          init_busy_d   = 1'b1;
          init_done_d   = 1'b0;
          init_error_d  = 1'b0;
          err_code_d    = 3'd0;
          card_v2_d     = 1'b0;
          card_hc_d     = 1'b0;
          cs_n_d        = 1'b1;
          retry_d       = '0;
          dummy_start_d = 1'b1;
          state_d       = DUMMY_ISSUE;
        end
      end

      DUMMY_ISSUE: begin
        timer_d = '0;
        state_d = DUMMY_WAIT;
      end

      DUMMY_WAIT: begin
        if (sd_if.dummy_done) begin
          cs_n_d  = 1'b0;
          state_d = CMD0_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          go_error  = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      CMD0_ISSUE, CMD8_ISSUE, CMD55_ISSUE, ACMD41_ISSUE, CMD58_ISSUE: begin
        sd_start_d = 1'b1;
        timer_d    = '0;
        sd_arg_d   = 32'h0;
        sd_nresp_d = 3'd0;
        case (state_q)
          CMD0_ISSUE: begin
            sd_cmd_d = 6'd0;
            sd_crc_d = 7'h4A;
            state_d  = CMD0_WAIT;
          end
          CMD8_ISSUE: begin
            sd_cmd_d   = 6'd8;
            sd_arg_d   = 32'h0000_01AA;
            sd_crc_d   = 7'h43;
            sd_nresp_d = 3'd4;
            state_d    = CMD8_WAIT;
          end
          CMD55_ISSUE: begin
            sd_cmd_d = 6'd55;
            sd_crc_d = 7'h32;
            state_d  = CMD55_WAIT;
          end
          ACMD41_ISSUE: begin
            sd_cmd_d = 6'd41;
            sd_arg_d = card_v2_q ? 32'h4000_0000 : 32'h0;
            sd_crc_d = 7'h3B;
            state_d  = ACMD41_WAIT;
          end
          default: begin
            sd_cmd_d   = 6'd58;
            sd_crc_d   = 7'h7E;
            sd_nresp_d = 3'd4;
            state_d    = CMD58_WAIT;
          end
        endcase
      end

      CMD0_WAIT, CMD8_WAIT, CMD55_WAIT, ACMD41_WAIT, CMD58_WAIT: begin
        // A done pulse takes priority over the timeout limit in the same cycle.
        if (sd_if.sd_done) begin
          case (state_q)
            CMD0_WAIT: begin
              if (sd_if.sd_r1 == 8'h01) state_d = CMD8_ISSUE;
              else begin go_error = 1'b1; fail_code = ERR_CMD0; end
            end
            CMD8_WAIT: begin
              if (sd_if.sd_r1 == 8'h01 && sd_if.sd_resp[11:0] == 12'h1AA) begin
                card_v2_d = 1'b1;
                state_d   = CMD55_ISSUE;
              end else if (sd_if.sd_r1 == 8'h05) begin
                card_v2_d = 1'b0;
                state_d   = CMD55_ISSUE;
              end else begin
                go_error  = 1'b1;
                fail_code = ERR_CMD8;
              end
            end
            CMD55_WAIT: begin
              if (sd_if.sd_r1 == 8'h00 || sd_if.sd_r1 == 8'h01) state_d = ACMD41_ISSUE;
              else begin go_error = 1'b1; fail_code = ERR_R1; end
            end
            ACMD41_WAIT: begin
              if (sd_if.sd_r1 == 8'h00) begin
                if (card_v2_q) state_d = CMD58_ISSUE;
                else begin go_done = 1'b1; card_hc_d = 1'b0; end
              end else if (sd_if.sd_r1 == 8'h01) begin
                retry_d = retry_q + 1'b1;
                if (retry_q == RETRY_LAST) begin
                  go_error  = 1'b1;
                  fail_code = ERR_RETRIES;
                end else begin
                  state_d = CMD55_ISSUE;
                end
              end else begin
                go_error  = 1'b1;
                fail_code = ERR_R1;
              end
            end
            default: begin
              if (sd_if.sd_r1 == 8'h00) begin
                card_hc_d = sd_if.sd_resp[30];
                go_done   = 1'b1;
              end else begin
                go_error  = 1'b1;
                fail_code = ERR_CMD58;
              end
            end
          endcase
        end else if (timer_q == TIMER_LAST) begin
          go_error  = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (go_done) begin
      state_d     = DONE;
      init_done_d = 1'b1;
      init_busy_d = 1'b0;
      cs_n_d      = 1'b1;
    end
    if (go_error) begin
      state_d      = ERROR;
      init_error_d = 1'b1;
      init_busy_d  = 1'b0;
      cs_n_d       = 1'b1;
      err_code_d   = fail_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      init_busy_q   <= 1'b0;
      init_done_q   <= 1'b0;
      init_error_q  <= 1'b0;
      err_code_q    <= 3'd0;
      card_v2_q     <= 1'b0;
      card_hc_q     <= 1'b0;
      cs_n_q        <= 1'b1;
      dummy_start_q <= 1'b0;
      sd_start_q    <= 1'b0;
      sd_cmd_q      <= 6'd0;
      sd_arg_q      <= 32'h0;
      sd_crc_q      <= 7'h0;
      sd_nresp_q    <= 3'd0;
      timer_q       <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      init_busy_q   <= init_busy_d;
      init_done_q   <= init_done_d;
      init_error_q  <= init_error_d;
      err_code_q    <= err_code_d;
      card_v2_q     <= card_v2_d;
      card_hc_q     <= card_hc_d;
      cs_n_q        <= cs_n_d;
      dummy_start_q <= dummy_start_d;
      sd_start_q    <= sd_start_d;
      sd_cmd_q      <= sd_cmd_d;
      sd_arg_q      <= sd_arg_d;
      sd_crc_q      <= sd_crc_d;
      sd_nresp_q    <= sd_nresp_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
    end
  end

  assign init_busy          = init_busy_q;
  assign init_done          = init_done_q;
  assign init_error         = init_error_q;
  assign err_code           = err_code_q;
  assign card_v2            = card_v2_q;
  assign card_hc            = card_hc_q;
  assign sd_if.cs_n         = cs_n_q;
  assign sd_if.dummy_start  = dummy_start_q;
  assign sd_if.dummy_count  = 8'(DUMMY_BYTES);
  assign sd_if.sd_start     = sd_start_q;
  assign sd_if.sd_cmd       = sd_cmd_q;
  assign sd_if.sd_arg       = sd_arg_q;
  assign sd_if.sd_crc       = sd_crc_q;
  assign sd_if.sd_nresponse = sd_nresp_q;

endmodule
